// File: rtl/llc_input_arbiter_pkg.sv
// Shared types and constants for the LLC input arbiter.
// Optional statistics counters are enabled with LLC_ARB_STATS_EN.
package llc_input_arbiter_pkg;

    typedef enum logic [1:0] {
        CH_RST_TB = 2'd0,
        CH_RSP    = 2'd1,
        CH_REQ    = 2'd2,
        CH_DMA    = 2'd3
    } llc_in_ch_t;

    localparam int unsigned LLC_ARB_STARVE_LIMIT = 8;
    localparam int unsigned LLC_ARB_STAT_W       = 16;

    // Counter width for a given limit; a zero limit still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

    function automatic logic [LLC_ARB_STAT_W-1:0] sat_inc(input logic [LLC_ARB_STAT_W-1:0] v);
        return (&v) ? v : v + LLC_ARB_STAT_W'(1);
    endfunction

endpackage

// File: rtl/llc_input_arbiter_if.sv
// Channel valid/pop signals and grant handshake between the LLC input queues and the arbiter.
// Statistics outputs exist only when LLC_ARB_STATS_EN is defined.
interface llc_input_arbiter_if;
    import llc_input_arbiter_pkg::*;

    logic       rst_tb_valid_in;
    logic       rsp_valid_in;
    logic       req_valid_in;
    logic       dma_req_valid_in;
    logic       req_stall;
    logic       dma_pending;
    logic       rst_tb_pop;
    logic       rsp_pop;
    logic       req_pop;
    logic       dma_req_pop;
    logic       grant_valid;
    logic [1:0] grant_ch;
    logic       grant_ready;
    logic       dma_promoted;
`ifdef LLC_ARB_STATS_EN
    logic [LLC_ARB_STAT_W-1:0] grant_cnt_rst_tb;
    logic [LLC_ARB_STAT_W-1:0] grant_cnt_rsp;
    logic [LLC_ARB_STAT_W-1:0] grant_cnt_req;
    logic [LLC_ARB_STAT_W-1:0] grant_cnt_dma;
    logic [LLC_ARB_STAT_W-1:0] stall_cycles;
`endif

    // Queue/decoder side.
    modport master (
        output rst_tb_valid_in, rsp_valid_in, req_valid_in, dma_req_valid_in,
        output req_stall, dma_pending, grant_ready,
        input  rst_tb_pop, rsp_pop, req_pop, dma_req_pop,
        input  grant_valid, grant_ch, dma_promoted
`ifdef LLC_ARB_STATS_EN
        , input grant_cnt_rst_tb, grant_cnt_rsp, grant_cnt_req, grant_cnt_dma, stall_cycles
`endif
    );

    // Arbiter side.
    modport slave (
        input  rst_tb_valid_in, rsp_valid_in, req_valid_in, dma_req_valid_in,
        input  req_stall, dma_pending, grant_ready,
        output rst_tb_pop, rsp_pop, req_pop, dma_req_pop,
        output grant_valid, grant_ch, dma_promoted
`ifdef LLC_ARB_STATS_EN
        , output grant_cnt_rst_tb, grant_cnt_rsp, grant_cnt_req, grant_cnt_dma, stall_cycles
`endif
    );

endinterface

// File: rtl/llc_input_arbiter_prio_sel.sv
// Combinational 4-way fixed-priority picker; promote swaps DMA above REQ.
module llc_arb_prio_sel
    import llc_input_arbiter_pkg::*;
(
    input  logic [3:0]  elig,
    input  logic        promote,
    output llc_in_ch_t  winner,
    output logic        any_valid
);

    always_comb begin
        winner    = CH_RST_TB;
        any_valid = |elig;
        if (elig[CH_RST_TB]) begin
            winner = CH_RST_TB;
        end else if (elig[CH_RSP]) begin
            winner = CH_RSP;
        end else if (promote && elig[CH_DMA]) begin
            winner = CH_DMA;
        end else if (elig[CH_REQ]) begin
            winner = CH_REQ;
        end else if (elig[CH_DMA]) begin
            winner = CH_DMA;
        end
    end

endmodule

// File: rtl/llc_input_arbiter.sv
// Registered arbiter selecting one LLC input channel per cycle for the decode stage.
// Define LLC_ARB_STATS_EN to add saturating grant/stall statistics counters.
module llc_input_arbiter
    import llc_input_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = LLC_ARB_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    llc_input_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = cnt_width(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    state_t            state_q;
    llc_in_ch_t        ch_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              promoted_q;

    logic [3:0]        elig;
    logic              promote_eff;
    llc_in_ch_t        winner;
    logic              any_valid;
    logic              load;

    always_comb begin
        elig            = '0;
        elig[CH_RST_TB] = bus.rst_tb_valid_in & ~bus.dma_pending;
        elig[CH_RSP]    = bus.rsp_valid_in;
        elig[CH_REQ]    = bus.req_valid_in & ~bus.req_stall;
        elig[CH_DMA]    = bus.dma_req_valid_in & ~bus.req_stall;
    end

    // A zero limit leaves DMA ahead of REQ unconditionally.
    assign promote_eff = promoted_q | (STARVE_LIMIT == 0);

    llc_arb_prio_sel u_prio_sel (
        .elig      (elig),
        .promote   (promote_eff),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign load = ~rst & any_valid & ((state_q == ST_EMPTY) | bus.grant_ready);

    // Starvation count for the round being loaded.
    always_comb begin
        cnt_d = '0;
        if (elig[CH_DMA] && (winner != CH_DMA)) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            ch_q       <= CH_RST_TB;
            cnt_q      <= '0;
            promoted_q <= 1'b0;
        end else if (load) begin
            state_q    <= ST_FULL;
            ch_q       <= winner;
            cnt_q      <= cnt_d;
            promoted_q <= (cnt_d == CNT_MAX);
        end else if (bus.grant_ready) begin
            state_q    <= ST_EMPTY;
        end
    end

    assign bus.grant_valid  = (state_q == ST_FULL);
    assign bus.grant_ch     = ch_q;
    assign bus.dma_promoted = promoted_q;

    assign bus.rst_tb_pop  = load & (winner == CH_RST_TB);
    assign bus.rsp_pop     = load & (winner == CH_RSP);
    assign bus.req_pop     = load & (winner == CH_REQ);
    assign bus.dma_req_pop = load & (winner == CH_DMA);

`ifdef LLC_ARB_STATS_EN
    logic [LLC_ARB_STAT_W-1:0] cnt_rst_tb_q;
    logic [LLC_ARB_STAT_W-1:0] cnt_rsp_q;
    logic [LLC_ARB_STAT_W-1:0] cnt_req_q;
    logic [LLC_ARB_STAT_W-1:0] cnt_dma_q;
    logic [LLC_ARB_STAT_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_rst_tb_q <= '0;
            cnt_rsp_q    <= '0;
            cnt_req_q    <= '0;
            cnt_dma_q    <= '0;
            stall_q      <= '0;
        end else begin
            if (bus.rst_tb_pop)  cnt_rst_tb_q <= sat_inc(cnt_rst_tb_q);
            if (bus.rsp_pop)     cnt_rsp_q    <= sat_inc(cnt_rsp_q);
            if (bus.req_pop)     cnt_req_q    <= sat_inc(cnt_req_q);
            if (bus.dma_req_pop) cnt_dma_q    <= sat_inc(cnt_dma_q);
            if ((state_q == ST_FULL) && !bus.grant_ready) stall_q <= sat_inc(stall_q);
        end
    end

    assign bus.grant_cnt_rst_tb = cnt_rst_tb_q;
    assign bus.grant_cnt_rsp    = cnt_rsp_q;
    assign bus.grant_cnt_req    = cnt_req_q;
    assign bus.grant_cnt_dma    = cnt_dma_q;
    assign bus.stall_cycles     = stall_q;
`endif

endmodule

// File: tb/tb_llc_input_arbiter.sv
// Directed self-checking bench for llc_input_arbiter (STARVE_LIMIT = 8).
// Statistics checks are included when LLC_ARB_STATS_EN is defined.
module tb_llc_input_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   nvec = 0;
    int   nerr = 0;

    llc_input_arbiter_if bus ();

    llc_input_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; registered outputs are read there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pops(input string tag, input logic [3:0] exp);
        #1;
        chk(tag, 16'({bus.dma_req_pop, bus.req_pop, bus.rsp_pop, bus.rst_tb_pop}), 16'(exp));
    endtask

    task automatic set_in(input logic r, input logic s, input logic q, input logic d);
        bus.rst_tb_valid_in  = r;
        bus.rsp_valid_in     = s;
        bus.req_valid_in     = q;
        bus.dma_req_valid_in = d;
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        bus.req_stall   = 1'b0;
        bus.dma_pending = 1'b0;
        bus.grant_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        do_reset();

        // Reset state; pops stay low while rst is asserted.
        chk("rst_grant_valid", 16'(bus.grant_valid), 16'd0);
        chk("rst_grant_ch", 16'(bus.grant_ch), 16'd0);
        chk("rst_promoted", 16'(bus.dma_promoted), 16'd0);
        rst = 1'b1;
        set_in(1'b1, 1'b1, 1'b1, 1'b1);
        pops("rst_no_pop", 4'b0000);
        tick();
        chk("rst_hold_empty", 16'(bus.grant_valid), 16'd0);

        // All four channels valid: RST_TB first, then RSP.
        do_reset();
        set_in(1'b1, 1'b1, 1'b1, 1'b1);
        pops("all_pop_rst_tb", 4'b0001);
        tick();
        chk("all_gv", 16'(bus.grant_valid), 16'd1);
        chk("all_ch0", 16'(bus.grant_ch), 16'd0);
        bus.rst_tb_valid_in = 1'b0;
        pops("all_pop_rsp", 4'b0010);
        tick();
        chk("all_ch1", 16'(bus.grant_ch), 16'd1);

        // Starvation: 8 REQ wins, then DMA promoted and granted.
        do_reset();
        set_in(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            pops($sformatf("starve_req_pop%0d", i), 4'b0100);
            chk($sformatf("starve_promo_pre%0d", i), 16'(bus.dma_promoted), 16'd0);
            tick();
            chk($sformatf("starve_ch%0d", i), 16'(bus.grant_ch), 16'd2);
        end
        chk("starve_promoted", 16'(bus.dma_promoted), 16'd1);
        pops("starve_dma_pop", 4'b1000);
        tick();
        chk("starve_ch_dma", 16'(bus.grant_ch), 16'd3);
        chk("starve_promo_clr", 16'(bus.dma_promoted), 16'd0);
        pops("starve_req_again", 4'b0100);
        tick();
        chk("starve_ch_req_again", 16'(bus.grant_ch), 16'd2);

        // Backpressure: held REQ grant stays stable while a new RSP waits.
        do_reset();
        set_in(1'b0, 1'b0, 1'b1, 1'b0);
        pops("bp_req_pop", 4'b0100);
        tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        bus.grant_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.req_stall   = 1'(i % 2);
            bus.dma_pending = 1'(i % 2);
            pops($sformatf("bp_no_pop%0d", i), 4'b0000);
            tick();
            chk($sformatf("bp_gv%0d", i), 16'(bus.grant_valid), 16'd1);
            chk($sformatf("bp_ch%0d", i), 16'(bus.grant_ch), 16'd2);
        end
        bus.req_stall   = 1'b0;
        bus.dma_pending = 1'b0;
        bus.grant_ready = 1'b1;
        pops("bp_rsp_pop", 4'b0010);
        tick();
        chk("bp_ch_rsp", 16'(bus.grant_ch), 16'd1);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("bp_drain", 16'(bus.grant_valid), 16'd0);

        // req_stall blocks REQ and DMA.
        do_reset();
        bus.req_stall = 1'b1;
        set_in(1'b0, 1'b0, 1'b1, 1'b1);
        pops("stall_no_pop", 4'b0000);
        tick();
        chk("stall_gv", 16'(bus.grant_valid), 16'd0);
        bus.req_stall = 1'b0;
        pops("stall_rel_pop", 4'b0100);
        tick();
        chk("stall_rel_gv", 16'(bus.grant_valid), 16'd1);
        chk("stall_rel_ch", 16'(bus.grant_ch), 16'd2);

        // dma_pending blocks RST_TB only.
        do_reset();
        bus.dma_pending = 1'b1;
        set_in(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            pops($sformatf("pend_req_pop%0d", i), 4'b0100);
            tick();
            chk($sformatf("pend_ch%0d", i), 16'(bus.grant_ch), 16'd2);
        end
        bus.dma_pending = 1'b0;
        pops("pend_rel_pop", 4'b0001);
        tick();
        chk("pend_rel_ch", 16'(bus.grant_ch), 16'd0);

        // Reset while holding a stalled grant.
        do_reset();
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b1, 1'b1, 1'b0);
        bus.grant_ready = 1'b0;
        tick();
        chk("hold_gv", 16'(bus.grant_valid), 16'd1);
        chk("hold_ch", 16'(bus.grant_ch), 16'd1);
`ifdef LLC_ARB_STATS_EN
        chk("stats_rsp_pre", bus.grant_cnt_rsp, 16'd1);
        chk("stats_stall_pre", bus.stall_cycles, 16'd1);
`endif
        rst = 1'b1;
        pops("hold_rst_no_pop", 4'b0000);
        tick();
        rst = 1'b0;
        bus.grant_ready = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("hold_rst_gv", 16'(bus.grant_valid), 16'd0);
        chk("hold_rst_ch", 16'(bus.grant_ch), 16'd0);
        chk("hold_rst_promo", 16'(bus.dma_promoted), 16'd0);
`ifdef LLC_ARB_STATS_EN
        chk("stats_rst_tb", bus.grant_cnt_rst_tb, 16'd0);
        chk("stats_rsp", bus.grant_cnt_rsp, 16'd0);
        chk("stats_req", bus.grant_cnt_req, 16'd0);
        chk("stats_dma", bus.grant_cnt_dma, 16'd0);
        chk("stats_stall", bus.stall_cycles, 16'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
